ip_vram_bsram: RTL and testbench

On-chip block-RAM VRAM responder for the VDP's vram_* request interface. It is a drop-in alternative to the SDRAM controller: same bus_* port set, same initial-busy semantics, and the same "no ready, fixed latency" contract.
- Used for low-resource builds and for simulation of the V9958 clone without an SDRAM model.
- After reset it clears the whole array, then serves one 32-bit read or masked write per cycle.

---
 rtl/vram_bus_pkg.sv | 11 +
 rtl/ip_vram_bsram_array.sv | 20 ++
 rtl/ip_vram_bsram.sv | 73 +++++++
 tb/tb_ip_vram_bsram.sv | 115 +++++++++++
 4 files changed

// File: rtl/vram_bus_pkg.sv
// vram_bus_pkg: shared constants, init states and mask helper for VRAM responders
package vram_bus_pkg;
  localparam int VRAM_DATA_W = 32;
  localparam int VRAM_MASK_W = 4;
  localparam int VRAM_READ_LATENCY = 2;
  localparam logic MASK_ACTIVE = 1'b1;
  typedef enum logic [1:0] {S_CLEAR, S_WAIT, S_READY} init_state_t;
  function automatic logic [VRAM_MASK_W-1:0] byte_en(input logic [VRAM_MASK_W-1:0] mask);
    return MASK_ACTIVE ? ~mask : mask;
  endfunction
endpackage

// File: rtl/ip_vram_bsram_array.sv
// ip_vram_bsram_array: single-port BSRAM, byte write-enables, registered read
module ip_vram_bsram_array
  import vram_bus_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic                   clk,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [VRAM_MASK_W-1:0] we,
  input  logic [VRAM_DATA_W-1:0] wdata,
  output logic [VRAM_DATA_W-1:0] rdata
);
  logic [VRAM_DATA_W-1:0] mem [2**ADDR_W];
  // no reset on the array or its output so the tools map it onto block RAM
  always_ff @(posedge clk) begin
    for (int i = 0; i < VRAM_MASK_W; i++)
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    rdata <= mem[addr];
  end
endmodule

// File: rtl/ip_vram_bsram.sv
// ip_vram_bsram: block-RAM VRAM responder with zero-fill init and fixed read latency
module ip_vram_bsram
  import vram_bus_pkg::*;
#(
  parameter int ADDR_W        = 16,
  parameter int CLEAR_ON_INIT = 1,
  parameter int INIT_WAIT     = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  output logic                   sdram_init_busy,
  input  logic [ADDR_W-1:0]      bus_address,
  input  logic                   bus_valid,
  input  logic                   bus_write,
  input  logic                   bus_refresh,
  input  logic [VRAM_DATA_W-1:0] bus_wdata,
  input  logic [VRAM_MASK_W-1:0] bus_wdata_mask,
  output logic [VRAM_DATA_W-1:0] bus_rdata,
  output logic                   bus_rdata_en
);
  localparam int WAIT_W = $clog2(INIT_WAIT + 1);
  localparam int CNT_W = (ADDR_W + 1 > WAIT_W) ? ADDR_W + 1 : WAIT_W;
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'((2**ADDR_W) - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(INIT_WAIT - 1);
  localparam init_state_t S_INIT = (CLEAR_ON_INIT != 0) ? S_CLEAR : S_WAIT;
  init_state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic clearing, accept, rd_q, unused_refresh;
  logic [ADDR_W-1:0] ram_addr;
  logic [VRAM_MASK_W-1:0] ram_we;
  logic [VRAM_DATA_W-1:0] ram_wd, ram_q;
  assign unused_refresh = bus_refresh;
  // init state and clear/wait counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end
  // init sequencing and the clear-versus-bus port mux
  always_comb begin
    state_nx = ((state == S_CLEAR && cnt == CLEAR_LAST) || (state == S_WAIT && cnt == WAIT_LAST)) ? S_READY : state;
    cnt_nx = (state == S_READY) ? cnt : cnt + 1'b1;
    sdram_init_busy = state != S_READY;
    clearing = state == S_CLEAR;
    accept = bus_valid & ~sdram_init_busy;
    ram_addr = clearing ? cnt[ADDR_W-1:0] : bus_address;
    ram_we = clearing ? '1 : ((accept & bus_write) ? byte_en(bus_wdata_mask) : '0);
    ram_wd = clearing ? '0 : bus_wdata;
  end
  ip_vram_bsram_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (ram_wd),
    .rdata (ram_q)
  );
  // read-valid tracks the array output stage; output register holds the last result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q         <= 1'b0;
      bus_rdata_en <= 1'b0;
      bus_rdata    <= '0;
    end else begin
      rd_q         <= accept & ~bus_write;
      bus_rdata_en <= rd_q;
      if (rd_q) bus_rdata <= ram_q;
    end
  end
endmodule

// File: tb/tb_ip_vram_bsram.sv
// tb_ip_vram_bsram: directed plus random checks against a behavioural VRAM model
module tb_ip_vram_bsram;
  localparam int AW = 4;
  localparam int DEPTH = 1 << AW;
  logic clk = 1'b0, reset_n = 1'b0;
  logic sdram_init_busy, bus_valid = 0, bus_write = 0, bus_refresh = 0, bus_rdata_en;
  logic [AW-1:0] bus_address = '0;
  logic [31:0] bus_wdata = '0, bus_rdata;
  logic [3:0] bus_wdata_mask = '0;
  typedef struct {int due; logic [31:0] data;} rd_t;
  rd_t pend[$];
  logic [31:0] mem [DEPTH];
  logic [31:0] last_rdata;
  int cyc, since_rel, checks, errors;

  ip_vram_bsram #(.ADDR_W(AW), .CLEAR_ON_INIT(1), .INIT_WAIT(16)) dut (
    .clk(clk), .reset_n(reset_n), .sdram_init_busy(sdram_init_busy),
    .bus_address(bus_address), .bus_valid(bus_valid), .bus_write(bus_write),
    .bus_refresh(bus_refresh), .bus_wdata(bus_wdata), .bus_wdata_mask(bus_wdata_mask),
    .bus_rdata(bus_rdata), .bus_rdata_en(bus_rdata_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic do_reset(input int hold);
    reset_n = 1'b0;
    pend.delete();
    #1;
    chk("reset_busy", 32'(sdram_init_busy), 32'd1);
    chk("reset_rdata", bus_rdata, 32'd0);
    chk("reset_rdata_en", 32'(bus_rdata_en), 32'd0);
    repeat (hold) @(posedge clk);
    #1;
    reset_n = 1'b1;
    since_rel = 0;
    last_rdata = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  endtask

  task automatic step(input logic v, input logic w, input logic [AW-1:0] a,
                      input logic [31:0] d, input logic [3:0] m, input logic r);
    bit busy_now, exp_en;
    bus_valid = v; bus_write = w; bus_address = a; bus_wdata = d;
    bus_wdata_mask = m; bus_refresh = r;
    @(posedge clk);
    cyc++;
    busy_now = since_rel < DEPTH;
    if (v && !busy_now) begin
      if (!w) pend.push_back('{cyc + 1, mem[a]});
      else for (int b = 0; b < 4; b++) if (!m[b]) mem[a][8*b +: 8] = d[8*b +: 8];
    end
    since_rel++;
    #1;
    bus_valid = 0; bus_write = 0; bus_refresh = 0;
    exp_en = pend.size() > 0 && pend[0].due == cyc;
    if (exp_en) last_rdata = pend.pop_front().data;
    chk("busy", 32'(sdram_init_busy), 32'(since_rel < DEPTH));
    chk("rdata_en", 32'(bus_rdata_en), 32'(exp_en));
    chk("rdata", bus_rdata, last_rdata);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, '0, 0);
  endtask

  initial begin
    cyc = 0; checks = 0; errors = 0; since_rel = 0; last_rdata = '0;
    #2;
    do_reset(2);
    idle(3);
    step(1, 1, 4'd3, 32'hFFFF_FFFF, 4'b0000, 0);
    while (since_rel < DEPTH) idle(1);
    step(1, 0, 4'd9, '0, '0, 0); idle(2);
    step(1, 0, 4'd3, '0, '0, 0); idle(2);
    step(1, 1, 4'd5, 32'h1234_5678, 4'b0000, 0);
    step(1, 0, 4'd5, '0, '0, 0); idle(2);
    chk("full_write", last_rdata, 32'h1234_5678);
    step(1, 1, 4'd5, 32'hAABB_CCDD, 4'b0101, 0);
    step(1, 0, 4'd5, '0, '0, 0); idle(2);
    chk("masked_write", bus_rdata, 32'hAA34_CC78);
    step(1, 1, 4'd1, 32'h11, 4'b0000, 1);
    step(1, 1, 4'd2, 32'h22, 4'b0000, 0);
    step(1, 1, 4'd3, 32'h33, 4'b0000, 1);
    step(1, 0, 4'd1, '0, '0, 1);
    step(1, 0, 4'd2, '0, '0, 0);
    step(1, 0, 4'd3, '0, '0, 1);
    idle(3);
    chk("pipelined_last", bus_rdata, 32'h33);
    do_reset(1);
    idle(10);
    do_reset(2);
    while (since_rel < DEPTH) idle(1);
    step(1, 0, 4'd5, '0, '0, 0); idle(2);
    chk("rezeroed", bus_rdata, 32'd0);
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), AW'($urandom), $urandom,
           4'($urandom), 1'($urandom));
    idle(2);
    step(1, 0, 4'd7, '0, '0, 0);
    do_reset(1);
    idle(3);
    while (since_rel < DEPTH) idle(1);
    step(1, 0, 4'd7, '0, '0, 0); idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
